dec_share_arb: RTL
==================

Name: dec_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one decrement datapath (d = a-1, DATAWIDTH wide) among NREQ requesters.
- Each cycle it grants at most one requester, captures that requester's operand, and registers the decremented result with the requester ID.
- The result leaves through a one-entry valid/ready output stage.
- Sits between the scheduled datapath operations and the shared arithmetic unit in the generated datapath.

Parameters:
- DATAWIDTH, 8, operand/result width.
- NREQ, 4, number of requesters (2..16).
- IDW, 2, width of requester ID; must equal ceil(log2(NREQ)).

Ports:
- Clk  input  1  clock, all state updates on rising edge.
- Rst  input  1  synchronous reset, active-low (asserted when 0, sampled on rising edge of Clk).
- Req  input  NREQ  per-requester request; bit i high = operand on Din slice i is valid.
- Din  input  NREQ*DATAWIDTH  flattened operands; requester i at bits [i*DATAWIDTH +: DATAWIDTH].
- Gnt  output  NREQ  one-hot combinational grant; Gnt[i]=1 means requester i's operand is consumed at this edge.
- Dout  output  DATAWIDTH  registered result, Din slice of granted requester minus 1.
- DoutId  output  IDW  registered index of requester that produced Dout.
- DoutValid  output  1  Dout/DoutId hold a result.
- DoutReady  input  1  downstream accepts the result when DoutValid&&DoutReady.
- Busy  output  1  registered; 1 when DoutValid=1 or any Req bit was high last cycle.

Behaviour:
- Reset (Rst=0 at edge): DoutValid=0, Dout=0, DoutId=0, Busy=0, round-robin pointer Ptr=0. Gnt is 0 while Rst=0. Reset mid-transfer discards the held result with no completion.
- Output stage state: EMPTY (DoutValid=0) and FULL (DoutValid=1).
- Accept condition: Acc = (DoutValid==0) || DoutReady.
- Gnt is nonzero only when Acc=1 and |Req=1.
- Arbitration: scan requesters starting at Ptr, ascending modulo NREQ; the first with Req=1 is granted. Purely combinational from Req, Ptr, DoutValid, DoutReady.
- On grant of i at an edge:
  - Dout <= Din[i] - 1 (modulo 2^DATAWIDTH).
  - DoutId <= i.
  - DoutValid <= 1.
  - Ptr <= (i+1) mod NREQ.
- Latency: the result is visible the cycle after the grant. Throughput is 1 result/cycle while DoutReady=1.
- FSM transitions:
  - EMPTY -> FULL on grant.
  - FULL & DoutReady & grant -> FULL (new result replaces old, back-to-back).
  - FULL & DoutReady & no grant -> EMPTY.
  - FULL & !DoutReady -> FULL, with Dout/DoutId held stable and Gnt=0.
- No grant: Ptr is unchanged.
- Requesters hold Req and Din until they see Gnt. A Req that drops before grant is simply not served.
- Starvation-free: any held Req is granted within NREQ accepted grants.
- Wrap-around: Din=0 gives Dout = 2^DATAWIDTH-1 (unless DEC_SAT_EN is defined).
- Simultaneous DoutReady and new grant in the same cycle: the old result is consumed and the new one is loaded; no bubble, no loss.
- Busy <= DoutValid_next || (|Req).

Optional Feature:
- Macro: DEC_SAT_EN.
- Defined: when the granted operand is 0, Dout <= 0 (saturate) and an extra registered output port Uflow (1 bit) is set to 1 alongside DoutValid; otherwise Uflow=0. Uflow resets to 0 and follows the same hold/replace rules as Dout.
- Not defined: plain modular decrement, and the Uflow port does not exist.

Test Plan:
- Reset, single request, wrap: hold Rst=0 for 2 cycles, then check all outputs = 0 and Gnt=0. Release, Req=4'b0100, Din slice2=8'h05, DoutReady=1 → Gnt=4'b0100. Next cycle: Dout=8'h04, DoutId=2, DoutValid=1, Ptr=3.
- Round-robin: Req=4'b1111 held, DoutReady=1, Din slices = 10,20,30,40 → grants 0,1,2,3,0 in successive cycles; Dout sequence 9,19,29,39,9 with a 1-cycle lag.
- Backpressure: produce one result, then DoutReady=0 for 3 cycles with Req=4'b0010 → Gnt=0, Dout/DoutId stable, DoutValid=1. Raise DoutReady → Gnt=4'b0010 the same cycle, and the new result appears next cycle with no gap.
- Underflow: Din slice0=8'h00, Req=4'b0001 → Dout=8'hFF without DEC_SAT_EN; with DEC_SAT_EN, Dout=8'h00 and Uflow=1.
- Reset mid-operation: DoutValid=1, DoutReady=0, assert Rst=0 for one edge → DoutValid=0 and Ptr=0. With Req=4'b1010 after release, the first grant is requester 1.
- Pointer skip: Ptr=3 (after granting 2), Req=4'b0101 → grant requester 0, then requester 2 if both are held.

Source files
------------

// File: rtl/dec_share_arb.sv
// Round-robin arbiter that shares one decrement unit among NREQ requesters,
// with a one-entry valid/ready output stage. Optional macro: DEC_SAT_EN.
module dec_share_arb #(
  parameter int DATAWIDTH = 8,
  parameter int NREQ      = 4,
  parameter int IDW       = 2
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [NREQ-1:0]           Req,
  input  logic [NREQ*DATAWIDTH-1:0] Din,
  output logic [NREQ-1:0]           Gnt,
  output logic [DATAWIDTH-1:0]      Dout,
  output logic [IDW-1:0]            DoutId,
  output logic                      DoutValid,
  input  logic                      DoutReady,
  output logic                      Busy
`ifdef DEC_SAT_EN
  ,
  output logic                      Uflow
`endif
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t               state, state_nxt;
  logic [IDW-1:0]       ptr;
  logic [IDW-1:0]       sel;
  logic [IDW-1:0]       scan;
  logic                 hit;
  logic                 acc;
  logic                 grant;
  logic [DATAWIDTH-1:0] opnd;
  logic [DATAWIDTH-1:0] res;
`ifdef DEC_SAT_EN
  logic                 uf;
`endif

  assign DoutValid = (state == FULL);
  assign acc       = (state == EMPTY) || DoutReady;
  assign grant     = Rst && acc && hit;

  // First requesting index at or after ptr, wrapping modulo NREQ.
  always_comb begin
    hit  = 1'b0;
    sel  = '0;
    scan = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan = IDW'((32'(ptr) + k) % NREQ);
      if (!hit && Req[scan]) begin
        hit = 1'b1;
        sel = scan;
      end
    end
  end

  always_comb begin
    Gnt = '0;
    if (grant) Gnt[sel] = 1'b1;
  end

  assign opnd = Din[sel*DATAWIDTH +: DATAWIDTH];

`ifdef DEC_SAT_EN
  assign uf  = (opnd == '0);
  assign res = uf ? '0 : opnd - DATAWIDTH'(1);
`else
  assign res = opnd - DATAWIDTH'(1);
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: if (grant) state_nxt = FULL;
      FULL:  if (DoutReady && !grant) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state  <= EMPTY;
      ptr    <= '0;
      Dout   <= '0;
      DoutId <= '0;
      Busy   <= 1'b0;
`ifdef DEC_SAT_EN
      Uflow  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      Busy  <= (state_nxt == FULL) || (|Req);
      if (grant) begin
        Dout   <= res;
        DoutId <= sel;
        ptr    <= (sel == IDW'(NREQ - 1)) ? '0 : sel + IDW'(1);
`ifdef DEC_SAT_EN
        Uflow  <= uf;
`endif
      end
    end
  end

endmodule
